// File: rtl/gpio_disp_pkg.sv
// Shared types, constants and helpers for the GPIO display-digit converter.
package gpio_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam int DIG_W = 4;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after
    // the next left shift, so bias it by 3 to carry into the next digit.
    function automatic logic [DIG_W-1:0] add3_adj(input logic [DIG_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/gpio_disp_conv_bcd_adj_row.sv
// One combinational row of add-3 adjusters across the whole BCD scratch word.
module bcd_adj_row
    import gpio_disp_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [DIG_W*DIGITS-1:0] i_scratch,
    output logic [DIG_W*DIGITS-1:0] o_adj
);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign o_adj[gi*DIG_W +: DIG_W] = add3_adj(i_scratch[gi*DIG_W +: DIG_W]);
        end
    endgenerate

endmodule

// File: rtl/gpio_disp_conv.sv
// Binary-to-display-digit converter: single-cycle hex nibble split or
// bit-serial double-dabble BCD conversion, behind a start/done handshake.
module gpio_disp_conv
    import gpio_disp_pkg::*;
#(
    parameter int IN_W   = 18,
    parameter int DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [IN_W-1:0]         bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [DIG_W*DIGITS-1:0] digits_out
);

    localparam int OUT_W = DIG_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int EXT_W = (IN_W > OUT_W) ? IN_W : OUT_W;

    disp_state_t             r_state;
    disp_state_t             w_state_next;
    logic [OUT_W-1:0]        r_scratch;
    logic [IN_W-1:0]         r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_acc;
    logic [OUT_W-1:0]        r_digits;
    logic                    r_ovf;

    logic                    w_load;
    logic                    w_last;
    logic [OUT_W-1:0]        w_adj;
    logic [OUT_W+IN_W-1:0]   w_cat;
    logic [EXT_W-1:0]        w_bin_ext;
    logic [OUT_W-1:0]        w_hex;
    logic                    w_hex_ovf;

    // A request is only taken while idle or in the single DONE cycle.
    assign w_load    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    // Hex path: widen to cover both widths, keep the low digits, flag any lost bit.
    assign w_bin_ext = EXT_W'(bin_in);
    assign w_hex     = w_bin_ext[OUT_W-1:0];
    assign w_hex_ovf = |(w_bin_ext >> OUT_W);

    bcd_adj_row #(
        .DIGITS    (DIGITS)
    ) u_adj (
        .i_scratch (r_scratch),
        .o_adj     (w_adj)
    );

    // Adjusted scratch and input shift register move left as one word.
    assign w_cat = {w_adj, r_shift} << 1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = mode ? SHIFT : DONE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift while converting, publish result on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scratch <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_acc     <= 1'b0;
            r_digits  <= '0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            if (mode) begin
                r_scratch <= '0;
                r_acc     <= 1'b0;
                r_shift   <= bin_in;
                r_cnt     <= CNT_W'(IN_W);
            end else begin
                r_digits  <= w_hex;
                r_ovf     <= w_hex_ovf;
            end
        end else if (r_state == SHIFT) begin
            r_scratch <= w_cat[OUT_W+IN_W-1:IN_W];
            r_shift   <= w_cat[IN_W-1:0];
            r_acc     <= r_acc | w_adj[OUT_W-1];
            r_cnt     <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_digits <= w_cat[OUT_W+IN_W-1:IN_W];
                r_ovf    <= r_acc | w_adj[OUT_W-1];
            end
        end
    end

    assign busy       = (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign overflow   = r_ovf;
    assign digits_out = r_digits;

endmodule

// File: tb/tb_gpio_disp_conv.sv
// Self-checking bench: three converter instances (8, 2 and 4 digits) share
// the same stimulus and are checked against an arithmetic reference model.
module tb_gpio_disp_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [17:0] bin_in = '0;

    logic        busy8, done8, ovf8;
    logic [31:0] dig8;
    logic        busy2, done2, ovf2;
    logic [7:0]  dig2;
    logic        busy4, done4, ovf4;
    logic [15:0] dig4;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gpio_disp_conv #(.IN_W(18), .DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin_in(bin_in),
        .busy(busy8), .done(done8), .overflow(ovf8), .digits_out(dig8)
    );
    gpio_disp_conv #(.IN_W(18), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin_in(bin_in),
        .busy(busy2), .done(done2), .overflow(ovf2), .digits_out(dig2)
    );
    gpio_disp_conv #(.IN_W(18), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bin_in(bin_in),
        .busy(busy4), .done(done4), .overflow(ovf4), .digits_out(dig4)
    );

    // Reference: expected packed digits from the numeric value.
    function automatic longint exp_dig(input bit m, input longint v, input int d);
        longint r = 0;
        longint q = v;
        if (!m) begin
            r = v & ((longint'(1) << (4 * d)) - 1);
        end else begin
            for (int i = 0; i < d; i++) begin
                r = r | ((q % 10) << (4 * i));
                q = q / 10;
            end
        end
        return r;
    endfunction

    // Reference: value does not fit in d digits of the chosen radix.
    function automatic bit exp_ovf(input bit m, input longint v, input int d);
        longint p = 1;
        if (!m) return (v >> (4 * d)) != 0;
        for (int i = 0; i < d; i++) p = p * 10;
        return v >= p;
    endfunction

    // Issue one request and wait (bounded) for done; lat = cycle index of done
    // counted from the cycle after the accepting edge (0 = never seen).
    task automatic do_conv(input bit m, input logic [17:0] v, output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; mode = m; bin_in = v;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy8) busy_cnt++;
            if (done8) begin lat = n; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy8 !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b want=0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_mis++; $display("FAIL reset_done got=%b want=0", done8); end
        n_cmp++; if (ovf8 !== 1'b0) begin n_mis++; $display("FAIL reset_ovf got=%b want=0", ovf8); end
        n_cmp++; if (dig8 !== 32'h0) begin n_mis++; $display("FAIL reset_dig got=%h want=0", dig8); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin n_mis++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy8, done8); end
    endtask

    task automatic test_directed();
        int lat, bc;
        do_conv(1'b1, 18'd262143, lat, bc);
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL dec_latency got=%0d want=19", lat); end
        n_cmp++; if (bc !== 18) begin n_mis++; $display("FAIL dec_busy_cycles got=%0d want=18", bc); end
        n_cmp++; if (dig8 !== 32'h00262143) begin n_mis++; $display("FAIL dec_262143 got=%h want=00262143", dig8); end
        n_cmp++; if (ovf8 !== 1'b0) begin n_mis++; $display("FAIL dec_262143_ovf got=%b want=0", ovf8); end
        n_cmp++; if (dig2 !== 8'h43 || ovf2 !== 1'b1) begin n_mis++; $display("FAIL dec2_262143 got=%h/%b want=43/1", dig2, ovf2); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_mis++; $display("FAIL done_one_cycle got=%b want=0", done8); end
        n_cmp++; if (dig8 !== 32'h00262143) begin n_mis++; $display("FAIL dig_hold got=%h want=00262143", dig8); end
        do_conv(1'b0, 18'h3FFFF, lat, bc);
        n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL hex_latency got=%0d want=1", lat); end
        n_cmp++; if (dig8 !== 32'h0003FFFF || ovf8 !== 1'b0) begin n_mis++; $display("FAIL hex_3ffff got=%h/%b want=0003ffff/0", dig8, ovf8); end
        do_conv(1'b1, 18'd0, lat, bc);
        n_cmp++; if (lat !== 19 || dig8 !== 32'h0 || ovf8 !== 1'b0) begin n_mis++; $display("FAIL dec_zero lat=%0d dig=%h ovf=%b want 19/0/0", lat, dig8, ovf8); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        do_conv(1'b1, 18'd100, lat, bc);
        n_cmp++; if (dig2 !== 8'h00 || ovf2 !== 1'b1) begin n_mis++; $display("FAIL dec2_100 got=%h/%b want=00/1", dig2, ovf2); end
        n_cmp++; if (done2 !== 1'b1) begin n_mis++; $display("FAIL dec2_done got=%b want=1", done2); end
        do_conv(1'b1, 18'd99, lat, bc);
        n_cmp++; if (dig2 !== 8'h99 || ovf2 !== 1'b0) begin n_mis++; $display("FAIL dec2_99 got=%h/%b want=99/0", dig2, ovf2); end
        do_conv(1'b0, 18'h10001, lat, bc);
        n_cmp++; if (dig4 !== 16'h0001 || ovf4 !== 1'b1) begin n_mis++; $display("FAIL hex4_10001 got=%h/%b want=0001/1", dig4, ovf4); end
        n_cmp++; if (dig8 !== 32'h00010001 || ovf8 !== 1'b0) begin n_mis++; $display("FAIL hex8_10001 got=%h/%b want=00010001/0", dig8, ovf8); end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        int early = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; bin_in = 18'd12345;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done8) begin lat = n; break; end
            if (n >= 2 && n <= 9) begin
                start = 1'b1; mode = n[0]; bin_in = 18'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL ignore_latency got=%0d want=19", lat); end
        n_cmp++; if (dig8 !== 32'h00012345 || ovf8 !== 1'b0) begin n_mis++; $display("FAIL ignore_result got=%h/%b want=00012345/0", dig8, ovf8); end
        n_cmp++; if (early !== 0) begin n_mis++; $display("FAIL ignore_early got=%0d want=0", early); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        logic [17:0] hv [3];
        @(negedge clk);
        start = 1'b1; mode = 1'b1; bin_in = 18'd5;
        @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            if (done8) break;
            @(negedge clk);
        end
        n_cmp++; if (dig8 !== 32'h5 || done8 !== 1'b1) begin n_mis++; $display("FAIL b2b_first got=%h done=%b want=5/1", dig8, done8); end
        bin_in = 18'd7;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done8) begin lat = n; break; end
            @(negedge clk);
        end
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL b2b_spacing got=%0d want=19", lat); end
        n_cmp++; if (dig8 !== 32'h7) begin n_mis++; $display("FAIL b2b_second got=%h want=7", dig8); end
        // Hex requests held back-to-back complete every cycle.
        for (int i = 0; i < 3; i++) hv[i] = 18'($urandom);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; bin_in = hv[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) bin_in = hv[i+1]; else start = 1'b0;
            n_cmp++;
            if (done8 !== 1'b1 || dig8 !== 32'(hv[i])) begin
                n_mis++; $display("FAIL hex_b2b_%0d done=%b got=%h want=%h", i, done8, dig8, 32'(hv[i]));
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, want_lat;
        bit m;
        logic [17:0] v;
        longint e;
        for (int t = 0; t < 30; t++) begin
            m = 1'($urandom);
            case ($urandom_range(0, 3))
                0: v = 18'($urandom_range(0, 99));
                1: v = 18'($urandom_range(0, 9999));
                default: v = 18'($urandom);
            endcase
            do_conv(m, v, lat, bc);
            want_lat = m ? 19 : 1;
            $display("conv %0d mode=%0d bin=%0d dig8=%h dig4=%h dig2=%h ovf=%b%b%b lat=%0d",
                     t, m, v, dig8, dig4, dig2, ovf8, ovf4, ovf2, lat);
            n_cmp++; if (lat !== want_lat) begin n_mis++; $display("FAIL rnd_latency t=%0d got=%0d want=%0d", t, lat, want_lat); end
            e = exp_dig(m, longint'(v), 8);
            n_cmp++; if (dig8 !== 32'(e) || ovf8 !== exp_ovf(m, longint'(v), 8)) begin n_mis++; $display("FAIL rnd_dig8 t=%0d got=%h/%b want=%h/%b", t, dig8, ovf8, 32'(e), exp_ovf(m, longint'(v), 8)); end
            e = exp_dig(m, longint'(v), 4);
            n_cmp++; if (dig4 !== 16'(e) || ovf4 !== exp_ovf(m, longint'(v), 4)) begin n_mis++; $display("FAIL rnd_dig4 t=%0d got=%h/%b want=%h/%b", t, dig4, ovf4, 16'(e), exp_ovf(m, longint'(v), 4)); end
            e = exp_dig(m, longint'(v), 2);
            n_cmp++; if (dig2 !== 8'(e) || ovf2 !== exp_ovf(m, longint'(v), 2)) begin n_mis++; $display("FAIL rnd_dig2 t=%0d got=%h/%b want=%h/%b", t, dig2, ovf2, 8'(e), exp_ovf(m, longint'(v), 2)); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int seen = 0;
        logic [17:0] v;
        do_conv(1'b0, 18'h2ABCD, lat, bc);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; bin_in = 18'd54321;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_mis++; $display("FAIL rst_mid_ctrl busy=%b done=%b want 0/0", busy8, done8); end
        n_cmp++; if (dig8 !== 32'h0 || ovf8 !== 1'b0) begin n_mis++; $display("FAIL rst_mid_data got=%h/%b want=0/0", dig8, ovf8); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        rst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL rst_mid_discard activity=%0d want=0", seen); end
        v = 18'($urandom_range(0, 99999999 % 262144));
        do_conv(1'b1, v, lat, bc);
        n_cmp++; if (lat !== 19 || dig8 !== 32'(exp_dig(1'b1, longint'(v), 8))) begin n_mis++; $display("FAIL rst_mid_after lat=%0d got=%h want=%h", lat, dig8, 32'(exp_dig(1'b1, longint'(v), 8))); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
